// File: rtl/wrc_tag_fifo_wb.sv
// Wishbone-slave timestamp tag queue: captures {tag, frame ID} pairs into a FIFO for host polling.
// Optional level interrupt (EN & not-empty) is built only when WRC_TAG_FIFO_IRQ_EN is defined.
module wrc_tag_fifo_wb #(
    parameter int g_log2_depth = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        tag_valid_i,
    input  logic [31:0] tag_i,
    input  logic [15:0] tag_fid_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o
);

    localparam int c_depth = 1 << g_log2_depth;
    localparam logic [g_log2_depth:0] c_full_count = (g_log2_depth + 1)'(c_depth);

    typedef enum logic [2:0] {
        REG_CSR     = 3'd0,
        REG_TAG     = 3'd1,
        REG_FID     = 3'd2,
        REG_COUNT   = 3'd3,
        REG_SCRATCH = 3'd4
    } reg_e;

    logic [31:0]             mem_tag [c_depth];
    logic [15:0]             mem_fid [c_depth];
    logic [g_log2_depth-1:0] wr_ptr;
    logic [g_log2_depth-1:0] rd_ptr;
    logic [g_log2_depth:0]   count;
    logic                    en;
    logic                    ovf;
    logic [15:0]             fid_q;
    logic [31:0]             scratch;

    logic        wb_req;
    logic        rd_req;
    logic        wr_req;
    logic        csr_wr;
    logic        flush;
    logic        ovf_clr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic [31:0] rd_data;
    logic        sel_unused;

    // Byte selects carry no meaning here: every access is a full word.
    assign sel_unused = ^wb_sel_i;

    // A request is only accepted while ack is low, giving two cycles per access.
    assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_req  = wb_req & ~wb_we_i;
    assign wr_req  = wb_req & wb_we_i;
    assign csr_wr  = wr_req && (wb_adr_i == REG_CSR);
    assign flush   = csr_wr & wb_dat_i[1];
    assign ovf_clr = csr_wr & wb_dat_i[4];

    assign empty = (count == '0);
    assign full  = (count == c_full_count);
    assign pop   = rd_req && (wb_adr_i == REG_TAG) && !empty;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push_req = tag_valid_i & en & ~flush;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        // NOTE: default assignment first so every path drives rd_data and no latch is inferred.
        rd_data = '0;
        case (wb_adr_i)
            REG_CSR:     rd_data = {27'd0, ovf, ~empty, full, 1'b0, en};
            REG_TAG:     rd_data = empty ? 32'd0 : mem_tag[rd_ptr];
            REG_FID:     rd_data = {16'd0, fid_q};
            REG_COUNT:   rd_data = 32'(count);
            REG_SCRATCH: rd_data = scratch;
            default:     rd_data = '0;
        endcase
    end

    // NOTE: storage has no reset; emptiness is tracked by count/pointers, so stale words are never read.
    always_ff @(posedge clk_sys_i) begin
        if (push) begin
            mem_tag[wr_ptr] <= tag_i;
            mem_fid[wr_ptr] <= tag_fid_i;
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            en       <= 1'b0;
            ovf      <= 1'b0;
            fid_q    <= '0;
            scratch  <= '0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= rd_req ? rd_data : 32'd0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (pop) fid_q <= mem_fid[rd_ptr];

            if (csr_wr) en <= wb_dat_i[0];

            if (wr_req && (wb_adr_i == REG_SCRATCH)) scratch <= wb_dat_i;

            // A fresh overflow outranks a simultaneous write-1-clear.
            if (flush)        ovf <= 1'b0;
            else if (drop)    ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef WRC_TAG_FIFO_IRQ_EN
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= en & ~empty;
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wrc_tag_fifo_wb.sv
// Directed bench for wrc_tag_fifo_wb: a vector table for register behaviour plus
// hand-written sequences for fill/overflow, coincident push+pop, flush and reset.
module tb_wrc_tag_fifo_wb;

    logic        clk_sys_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tag_valid_i = 1'b0;
    logic [31:0] tag_i = '0;
    logic [15:0] tag_fid_i = '0;
    logic [2:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic        irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    wrc_tag_fifo_wb #(.g_log2_depth(4)) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .tag_valid_i (tag_valid_i),
        .tag_i       (tag_i),
        .tag_fid_i   (tag_fid_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_ack_o    (wb_ack_o),
        .irq_o       (irq_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ST} op_e;
    typedef struct {
        op_e         op;
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [15:0] fid;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone access; optionally strobes a tag into the same edge that accepts the request.
    task automatic wb_access(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                             input logic push, input logic [31:0] tag, input logic [15:0] fid,
                             output logic [31:0] rdat);
        logic got;
        @(negedge clk_sys_i);
        while (wb_ack_o) @(negedge clk_sys_i);
        wb_cyc_i    = 1'b1;
        wb_stb_i    = 1'b1;
        wb_we_i     = we;
        wb_adr_i    = adr;
        wb_dat_i    = wdat;
        tag_valid_i = push;
        tag_i       = tag;
        tag_fid_i   = fid;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk_sys_i);
            #1;
            tag_valid_i = 1'b0;
            if (wb_ack_o) got = 1'b1;
        end
        rdat     = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) check("ack_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] rdat);
        wb_access(1'b0, adr, 32'd0, 1'b0, 32'd0, 16'd0, rdat);
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(1'b1, adr, wdat, 1'b0, 32'd0, 16'd0, dummy);
    endtask

    task automatic strobe(input logic [31:0] tag, input logic [15:0] fid);
        @(negedge clk_sys_i);
        tag_valid_i = 1'b1;
        tag_i       = tag;
        tag_fid_i   = fid;
        @(posedge clk_sys_i);
        #1;
        tag_valid_i = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;

        // op, adr, wdata/tag, fid, expected read value
        vecs.push_back('{OP_RD, 3'd0, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd4, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_WR, 3'd4, 32'hDEAD,     16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd4, 32'h0,        16'h0,  32'h0000DEAD});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd2, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_WR, 3'd0, 32'h1,        16'h0,  32'h0});
        vecs.push_back('{OP_ST, 3'd0, 32'h12345678, 16'hAB, 32'h0});
        vecs.push_back('{OP_RD, 3'd0, 32'h0,        16'h0,  32'h9});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h1});
        vecs.push_back('{OP_RD, 3'd1, 32'h0,        16'h0,  32'h12345678});
        vecs.push_back('{OP_RD, 3'd2, 32'h0,        16'h0,  32'h000000AB});
        vecs.push_back('{OP_RD, 3'd0, 32'h0,        16'h0,  32'h1});
        vecs.push_back('{OP_RD, 3'd1, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_WR, 3'd5, 32'hFFFFFFFF, 16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd5, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_WR, 3'd1, 32'hFFFFFFFF, 16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_WR, 3'd2, 32'h1234,     16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd2, 32'h0,        16'h0,  32'h000000AB});
        vecs.push_back('{OP_WR, 3'd0, 32'h3,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd0, 32'h0,        16'h0,  32'h1});
        vecs.push_back('{OP_WR, 3'd0, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_ST, 3'd0, 32'hA1,       16'h1,  32'h0});
        vecs.push_back('{OP_ST, 3'd0, 32'hA2,       16'h2,  32'h0});
        vecs.push_back('{OP_ST, 3'd0, 32'hA3,       16'h3,  32'h0});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd0, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd1, 32'h0,        16'h0,  32'h0});
        vecs.push_back('{OP_RD, 3'd3, 32'h0,        16'h0,  32'h0});

        repeat (3) @(posedge clk_sys_i);
        #1;
        check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk_sys_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_RD: begin
                    wb_read(vecs[i].adr, rd);
                    check($sformatf("vec%0d_rd%0d", i, vecs[i].adr), rd, vecs[i].exp);
                end
                OP_WR: wb_write(vecs[i].adr, vecs[i].dat);
                default: strobe(vecs[i].dat, vecs[i].fid);
            endcase
        end

        // Data output returns to zero once the ack cycle is over.
        @(posedge clk_sys_i);
        #1;
        check("idle_ack", {31'd0, wb_ack_o}, 32'd0);
        check("idle_dat", wb_dat_o, 32'd0);

        // Fill past capacity: 17 pushes, the last one overflows.
        wb_write(3'd0, 32'h1);
        for (int t = 1; t <= 17; t++) strobe(t, 16'(t));
        wb_read(3'd0, rd);
        check("full_csr", rd, 32'h1D);   // EN|NE|FULL|OVF
        wb_read(3'd3, rd);
        check("full_count", rd, 32'd16);
        for (int t = 1; t <= 16; t++) begin
            wb_read(3'd1, rd);
            check($sformatf("drain_tag%0d", t), rd, t);
        end
        wb_read(3'd2, rd);
        check("drain_fid", rd, 32'd16);
        wb_read(3'd0, rd);
        check("drained_csr", rd, 32'h11);
        wb_write(3'd0, 32'h11);
        wb_read(3'd0, rd);
        check("ovf_clr_csr", rd, 32'h1);

        // Full FIFO, push lands on the same edge as a TAG pop: no overflow, new tag goes last.
        for (int t = 101; t <= 116; t++) strobe(t, 16'(t));
        wb_access(1'b0, 3'd1, 32'd0, 1'b1, 32'd200, 16'h00C8, rd);
        check("coinc_pop", rd, 32'd101);
        wb_read(3'd0, rd);
        check("coinc_csr", rd, 32'h0D);
        wb_read(3'd3, rd);
        check("coinc_count", rd, 32'd16);
        for (int t = 102; t <= 116; t++) begin
            wb_read(3'd1, rd);
            check($sformatf("coinc_tag%0d", t), rd, t);
        end
        wb_read(3'd1, rd);
        check("coinc_last", rd, 32'd200);
        wb_read(3'd2, rd);
        check("coinc_fid", rd, 32'h000000C8);

        // Empty FIFO, push coincident with TAG read: read sees empty, push still lands.
        wb_access(1'b0, 3'd1, 32'd0, 1'b1, 32'h55, 16'h5, rd);
        check("empty_coinc_rd", rd, 32'd0);
        wb_read(3'd3, rd);
        check("empty_coinc_count", rd, 32'd1);
        wb_read(3'd1, rd);
        check("empty_coinc_tag", rd, 32'h55);

        // Interrupt follows EN & NE one cycle later when built in.
        strobe(32'h66, 16'h6);
        @(posedge clk_sys_i);
        #1;
`ifdef WRC_TAG_FIFO_IRQ_EN
        check("irq_high", {31'd0, irq_o}, 32'd1);
`else
        check("irq_off", {31'd0, irq_o}, 32'd0);
`endif
        wb_read(3'd1, rd);
        check("irq_pop_tag", rd, 32'h66);
        @(posedge clk_sys_i);
        #1;
        check("irq_low_pop", {31'd0, irq_o}, 32'd0);

        // Flush with 5 entries, a push in the flush cycle is discarded, FID kept.
        for (int t = 1; t <= 5; t++) strobe(t, 16'(t));
        wb_access(1'b1, 3'd0, 32'h3, 1'b1, 32'h77, 16'h7, rd);
        wb_read(3'd3, rd);
        check("flush_count", rd, 32'd0);
        wb_read(3'd0, rd);
        check("flush_csr", rd, 32'h1);
        wb_read(3'd2, rd);
        check("flush_fid", rd, 32'h00000006);
        check("flush_irq", {31'd0, irq_o}, 32'd0);
        strobe(32'h88, 16'h8);
        wb_read(3'd1, rd);
        check("post_flush_tag", rd, 32'h88);

        // Reset asserted while a request is pending: no ack, everything back to reset values.
        wb_write(3'd4, 32'hCAFE);
        strobe(32'h99, 16'h9);
        @(negedge clk_sys_i);
        while (wb_ack_o) @(negedge clk_sys_i);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 3'd4;
        rst_i    = 1'b1;
        @(posedge clk_sys_i);
        #1;
        check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk_sys_i);
        rst_i = 1'b0;
        wb_read(3'd4, rd);
        check("rst_scratch", rd, 32'd0);
        wb_read(3'd3, rd);
        check("rst_count", rd, 32'd0);
        wb_read(3'd0, rd);
        check("rst_csr", rd, 32'd0);
        wb_read(3'd2, rd);
        check("rst_fid", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
